// File: rtl/interrupt_sequencer.sv
// Vectored interrupt sequencer between an 8-input interrupt controller and the CPU.
// Handles priority nesting, the status-clear write, and sharing the controller port with the CPU.
module interrupt_sequencer #(
   parameter logic [15:0] VECTOR_BASE  = 16'h0010,
   parameter int          VECTOR_SHIFT = 2,
   parameter int          HOLDOFF      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ic_int_rq,
   input  logic [2:0]  ic_int_addr,
   input  logic        int_enable,
   input  logic        cpu_ack,
   input  logic        cpu_reti,
   input  logic        cpu_ce,
   input  logic        cpu_wren,
   input  logic        cpu_ri_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_irq,
   output logic [15:0] cpu_vector,
   output logic [7:0]  in_service,
   output logic        ic_ce,
   output logic        ic_wren,
   output logic        ic_ri_addr,
   output logic [7:0]  ic_wdata
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      CLEAR,
      SETTLE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [2:0]  cur_addr;
   logic [2:0]  cur_addr_next;
   logic [7:0]  in_service_next;
   logic [3:0]  settle_cnt;
   logic [3:0]  settle_cnt_next;

   logic [2:0]  lowest_idx;
   logic [7:0]  lowest_bit;
   logic        eligible;
   logic        seq_write;

   // Lowest set in-service index is the priority currently being serviced.
   always_comb begin
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (in_service[i]) begin
            lowest_idx = 3'(i);
         end
      end
   end

   assign lowest_bit = in_service & (~in_service + 8'd1);
   assign eligible   = ic_int_rq & int_enable &
                       ((in_service == 8'd0) | (ic_int_addr < lowest_idx));
   assign seq_write  = (state == CLEAR) & ~cpu_ce;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_addr   <= 3'd0;
         in_service <= 8'd0;
         settle_cnt <= 4'd0;
      end else begin
         state      <= state_next;
         cur_addr   <= cur_addr_next;
         in_service <= in_service_next;
         settle_cnt <= settle_cnt_next;
      end
   end

   // Next-state and datapath updates; reti clears before a same-cycle ack sets.
   always_comb begin
      state_next      = state;
      cur_addr_next   = cur_addr;
      settle_cnt_next = settle_cnt;
      in_service_next = in_service;

      if (cpu_reti) begin
         in_service_next = in_service & ~lowest_bit;
      end

      unique case (state)
         IDLE: begin
            if (eligible) begin
               cur_addr_next = ic_int_addr;
               state_next    = REQ;
            end
         end
         REQ: begin
            if (cpu_ack) begin
               in_service_next = in_service_next | (8'h01 << cur_addr);
               state_next      = CLEAR;
            end else if (!int_enable) begin
               state_next = IDLE;
            end
         end
         CLEAR: begin
            if (!cpu_ce) begin
               settle_cnt_next = 4'(HOLDOFF);
               state_next      = SETTLE;
            end
         end
         SETTLE: begin
            settle_cnt_next = settle_cnt - 4'd1;
            if (settle_cnt <= 4'd1) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign cpu_irq    = (state == REQ);
   assign cpu_vector = VECTOR_BASE + (16'(cur_addr) << VECTOR_SHIFT);

   // The CPU always wins the controller port; the clear write simply waits in CLEAR.
   always_comb begin
      ic_ce      = 1'b0;
      ic_wren    = 1'b0;
      ic_ri_addr = 1'b0;
      ic_wdata   = 8'd0;
      if (cpu_ce) begin
         ic_ce      = 1'b1;
         ic_wren    = cpu_wren;
         ic_ri_addr = cpu_ri_addr;
         ic_wdata   = cpu_wdata;
      end else if (seq_write) begin
         ic_ce      = 1'b1;
         ic_wren    = 1'b1;
         ic_ri_addr = 1'b0;
         ic_wdata   = ~(8'h01 << cur_addr);
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: request/ack/clear flow, nesting, port arbitration,
// enable withdrawal, holdoff after the clear write, and reset mid-operation.
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_int_rq;
   logic [2:0]  ic_int_addr;
   logic        int_enable;
   logic        cpu_ack;
   logic        cpu_reti;
   logic        cpu_ce;
   logic        cpu_wren;
   logic        cpu_ri_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_irq;
   logic [15:0] cpu_vector;
   logic [7:0]  in_service;
   logic        ic_ce;
   logic        ic_wren;
   logic        ic_ri_addr;
   logic [7:0]  ic_wdata;

   int checks   = 0;
   int failures = 0;

   interrupt_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .ic_int_rq   (ic_int_rq),
      .ic_int_addr (ic_int_addr),
      .int_enable  (int_enable),
      .cpu_ack     (cpu_ack),
      .cpu_reti    (cpu_reti),
      .cpu_ce      (cpu_ce),
      .cpu_wren    (cpu_wren),
      .cpu_ri_addr (cpu_ri_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_irq     (cpu_irq),
      .cpu_vector  (cpu_vector),
      .in_service  (in_service),
      .ic_ce       (ic_ce),
      .ic_wren     (ic_wren),
      .ic_ri_addr  (ic_ri_addr),
      .ic_wdata    (ic_wdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_idle_port(input string tag);
      check_output({tag, "_ce"}, 16'(ic_ce), 16'h0);
      check_output({tag, "_wren"}, 16'(ic_wren), 16'h0);
      check_output({tag, "_wdata"}, 16'(ic_wdata), 16'h0);
   endtask

   initial begin
      rst = 1'b1; ic_int_rq = 1'b0; ic_int_addr = 3'd0; int_enable = 1'b0;
      cpu_ack = 1'b0; cpu_reti = 1'b0; cpu_ce = 1'b0; cpu_wren = 1'b0;
      cpu_ri_addr = 1'b0; cpu_wdata = 8'h00;
      tick();
      tick();
      check_output("rst_irq", 16'(cpu_irq), 16'h0);
      check_output("rst_vector", cpu_vector, 16'h0010);
      check_output("rst_insvc", 16'(in_service), 16'h00);
      check_idle_port("rst_port");
      rst = 1'b0;

      // 1: source 3, ack, clear write
      int_enable = 1'b1; ic_int_rq = 1'b1; ic_int_addr = 3'd3;
      tick();
      check_output("t1_irq", 16'(cpu_irq), 16'h1);
      check_output("t1_vector", cpu_vector, 16'h001C);
      ic_int_rq = 1'b0; cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      #1;
      check_output("t1_irq_drop", 16'(cpu_irq), 16'h0);
      check_output("t1_ic_ce", 16'(ic_ce), 16'h1);
      check_output("t1_ic_wren", 16'(ic_wren), 16'h1);
      check_output("t1_ic_ri", 16'(ic_ri_addr), 16'h0);
      check_output("t1_ic_wdata", 16'(ic_wdata), 16'h00F7);
      check_output("t1_insvc", 16'(in_service), 16'h08);
      tick();
      check_idle_port("t1_settle_port");
      tick();
      tick();

      // 2: nesting under in_service=08
      ic_int_rq = 1'b1; ic_int_addr = 3'd5;
      tick();
      check_output("t2_lower_blocked", 16'(cpu_irq), 16'h0);
      ic_int_addr = 3'd3;
      tick();
      check_output("t2_equal_blocked", 16'(cpu_irq), 16'h0);
      ic_int_addr = 3'd1;
      tick();
      check_output("t2_irq", 16'(cpu_irq), 16'h1);
      check_output("t2_vector", cpu_vector, 16'h0014);
      ic_int_rq = 1'b0; cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      #1;
      check_output("t2_insvc", 16'(in_service), 16'h0A);
      check_output("t2_ic_wdata", 16'(ic_wdata), 16'h00FD);
      tick();
      tick();
      tick();
      cpu_reti = 1'b1;
      tick();
      check_output("t2_reti1", 16'(in_service), 16'h08);
      tick();
      cpu_reti = 1'b0;
      check_output("t2_reti2", 16'(in_service), 16'h00);
      tick();
      check_output("t2_reti_empty", 16'(in_service), 16'h00);

      // 5: same source held through SETTLE (reti frees it during CLEAR)
      ic_int_rq = 1'b1; ic_int_addr = 3'd2;
      tick();
      check_output("t5_irq", 16'(cpu_irq), 16'h1);
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      check_output("t5_insvc", 16'(in_service), 16'h04);
      cpu_reti = 1'b1;
      tick();
      cpu_reti = 1'b0;
      check_output("t5_insvc_freed", 16'(in_service), 16'h00);
      check_output("t5_settle1", 16'(cpu_irq), 16'h0);
      tick();
      check_output("t5_settle2", 16'(cpu_irq), 16'h0);
      tick();
      check_output("t5_idle", 16'(cpu_irq), 16'h0);
      tick();
      check_output("t5_retake", 16'(cpu_irq), 16'h1);
      check_output("t5_vector", cpu_vector, 16'h0018);

      // 4: int_enable dropped while in REQ
      ic_int_rq = 1'b0; int_enable = 1'b0;
      tick();
      check_output("t4_irq", 16'(cpu_irq), 16'h0);
      check_output("t4_insvc", 16'(in_service), 16'h00);
      check_idle_port("t4_port");
      tick();
      check_idle_port("t4_port_later");
      int_enable = 1'b1;

      // 3: CPU owns the port during CLEAR
      ic_int_rq = 1'b1; ic_int_addr = 3'd6;
      tick();
      check_output("t3_irq", 16'(cpu_irq), 16'h1);
      ic_int_rq = 1'b0; cpu_ack = 1'b1;
      cpu_ce = 1'b1; cpu_wren = 1'b1; cpu_ri_addr = 1'b1; cpu_wdata = 8'h55;
      tick();
      cpu_ack = 1'b0;
      #1;
      check_output("t3_insvc", 16'(in_service), 16'h40);
      check_output("t3_mirror_ce", 16'(ic_ce), 16'h1);
      check_output("t3_mirror_ri", 16'(ic_ri_addr), 16'h1);
      check_output("t3_mirror_wdata", 16'(ic_wdata), 16'h0055);
      tick();
      check_output("t3_mirror2_wdata", 16'(ic_wdata), 16'h0055);
      check_output("t3_mirror2_ri", 16'(ic_ri_addr), 16'h1);
      cpu_ce = 1'b0; cpu_wren = 1'b0; cpu_ri_addr = 1'b0; cpu_wdata = 8'h00;
      #1;
      check_output("t3_clear_ce", 16'(ic_ce), 16'h1);
      check_output("t3_clear_wren", 16'(ic_wren), 16'h1);
      check_output("t3_clear_ri", 16'(ic_ri_addr), 16'h0);
      check_output("t3_clear_wdata", 16'(ic_wdata), 16'h00BF);
      tick();
      check_idle_port("t3_after");
      tick();
      tick();
      cpu_reti = 1'b1;
      tick();
      cpu_reti = 1'b0;
      check_output("t3_reti", 16'(in_service), 16'h00);

      // 6: reset in REQ, then reset in CLEAR
      ic_int_rq = 1'b1; ic_int_addr = 3'd4;
      tick();
      check_output("t6_req_irq", 16'(cpu_irq), 16'h1);
      rst = 1'b1; ic_int_rq = 1'b0;
      tick();
      rst = 1'b0;
      check_output("t6_req_rst_irq", 16'(cpu_irq), 16'h0);
      check_output("t6_req_rst_vector", cpu_vector, 16'h0010);
      check_idle_port("t6_req_rst_port");
      ic_int_rq = 1'b1; ic_int_addr = 3'd7;
      tick();
      ic_int_rq = 1'b0; cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
      check_output("t6_clr_insvc", 16'(in_service), 16'h80);
      check_output("t6_clr_ce", 16'(ic_ce), 16'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("t6_clr_rst_insvc", 16'(in_service), 16'h00);
      check_output("t6_clr_rst_irq", 16'(cpu_irq), 16'h0);
      check_output("t6_clr_rst_vector", cpu_vector, 16'h0010);
      check_idle_port("t6_clr_rst_port");
      tick();
      check_idle_port("t6_clr_rst_port_later");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
